// File: rtl/adc_serial_responder_if.sv
// Serial ADC link bundle between an initiator and the responder.
// Carries frame select, serial clock, sample load and response pins.
interface adc_serial_responder_if #(
  parameter int DATA_BITS = 8
);
  logic                 cs;
  logic                 sclk;
  logic [DATA_BITS-1:0] sampleData;
  logic                 sampleValid;
  logic                 sdo;
  logic                 sdoOe;
  logic                 busy;
  logic                 frameDone;
  logic                 frameAbort;

  modport master (
    output cs, sclk, sampleData, sampleValid,
    input  sdo, sdoOe, busy, frameDone, frameAbort
  );

  modport slave (
    input  cs, sclk, sampleData, sampleValid,
    output sdo, sdoOe, busy, frameDone, frameAbort
  );
endinterface

// File: rtl/adc_serial_responder.sv
// Device end of a serial ADC read link: shifts a held sample out on sdo
// under an external cs/sclk pair, oversampled by the system clock.
module adc_serial_responder #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_ZEROS = 4,
  parameter int DATA_BITS  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  adc_serial_responder_if.slave bus
);

  localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int CW    = $clog2(FRAME_BITS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;

  logic csM_q, csS_q, csP_q;
  logic sclkM_q, sclkS_q, sclkP_q;
  logic [1:0] vld_q;
  logic armed_q;

  logic csFall, csRise, sclkFall;
  logic [FRAME_BITS-1:0] frame;

  assign csFall   = csP_q & ~csS_q;
  assign csRise   = ~csP_q & csS_q;
  assign sclkFall = sclkP_q & ~sclkS_q;
  assign frame    = FRAME_BITS'(hold_d) << TRAIL;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      csM_q   <= 1'b1;
      csS_q   <= 1'b1;
      csP_q   <= 1'b1;
      sclkM_q <= 1'b1;
      sclkS_q <= 1'b1;
      sclkP_q <= 1'b1;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      csM_q   <= bus.cs;
      csS_q   <= csM_q;
      csP_q   <= csS_q;
      sclkM_q <= bus.sclk;
      sclkS_q <= sclkM_q;
      sclkP_q <= sclkS_q;
      vld_q   <= {vld_q[0], 1'b1};
      // cs must be seen high after reset before a fall may open a frame
      armed_q <= armed_q | (vld_q[1] & csS_q);
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    hold_d  = bus.sampleValid ? bus.sampleData : hold_q;
    unique case (state_q)
      IDLE: begin
        if (csFall && armed_q) begin
          shift_d = frame;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (csRise) begin
          state_d = IDLE;
          abort_d = 1'b1;
          cnt_d   = '0;
          shift_d = '0;
        end else if (sclkFall) begin
          if (cnt_q == CW'(FRAME_BITS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            cnt_d   = CW'(FRAME_BITS);
            shift_d = '0;
          end else begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (csRise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sdo        = (state_q == SHIFT) & shift_q[FRAME_BITS-1];
  assign bus.sdoOe      = ~csS_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.frameDone  = done_q;
  assign bus.frameAbort = abort_q;

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Serial-ADC responder: the device end of the ADC read link that the WAC ADC controller drives.
- Drives sdo from a loaded 8-bit sample in response to an externally supplied cs/sclk pair.
- Used for board-level loopback and self-test: it sits on the FPGA in place of an ADC chip, fed by test-pattern or EPP-written data.
- Oversamples cs/sclk with the system clock; fully synchronous.

Parameters:
- FRAME_BITS, 16, total sclk falling edges per frame
- LEAD_ZEROS, 4, zero bits sent before the data MSB
- DATA_BITS, 8, sample width, sent MSB first; remaining FRAME_BITS-LEAD_ZEROS-DATA_BITS bits are trailing zeros

Ports:
- clk  in  1  system clock, must be at least 8x the sclk frequency
- rst_n  in  1  synchronous active-low reset
- cs  in  1  frame select from the initiator, active low, asynchronous to clk
- sclk  in  1  serial clock from the initiator, asynchronous to clk, idles high
- sampleData  in  DATA_BITS  next sample value
- sampleValid  in  1  one-cycle load strobe for sampleData
- sdo  out  1  serial data to the initiator
- sdoOe  out  1  output enable for the sdo pad; 1 while synced cs is low
- busy  out  1  1 while a frame is in progress (state SHIFT)
- frameDone  out  1  one-cycle pulse when a full frame completes
- frameAbort  out  1  one-cycle pulse when cs rises mid-frame

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sdo=0, sdoOe=0, busy=0, frameDone=0, frameAbort=0, holding=0, shift=0, bitCnt=0, sync flops csS=1 and sclkS=1.
- Synchronisers: cs and sclk each pass through 2 flops.
- Edge detect: compare the second flop with a third (previous) flop. csFall, csRise and sclkFall are one-cycle pulses.
- Holding register: loads sampleData on any cycle with sampleValid=1, in any state. It never alters a frame already in progress.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On csFall: shift <= {LEAD_ZEROS zeros, holding, trailing zeros}, bitCnt <= 0, state <= SHIFT.
  - sdo presents shift MSB (0) from the next cycle.
  - If sampleValid and csFall occur in the same cycle, the frame snapshots the new sampleData (holding bypass).
- SHIFT:
  - Each sclkFall: shift <= shift<<1, bitCnt <= bitCnt+1.
  - sdo is always the shift MSB, so the initiator samples on sclk rising.
  - When sclkFall occurs with bitCnt=FRAME_BITS-1: state <= DONE, frameDone=1 for one cycle, sdo <= 0.
  - csRise while in SHIFT: state <= IDLE, frameAbort=1 for one cycle, sdo <= 0, bitCnt <= 0.
  - If csRise and sclkFall occur in the same cycle, abort wins.
- DONE:
  - sdo held 0; extra sclk edges are ignored.
  - csRise: state <= IDLE with no pulse.
  - csFall cannot occur without a prior csRise.
- busy=1 only in SHIFT. sdoOe = ~csS (synced cs, second flop).
- Latency: sdo updates 3 clk cycles after the physical sclk falling edge (2 sync flops + 1 edge/shift register). The first bit is valid 3 cycles after the cs falling edge.
- bitCnt width is clog2(FRAME_BITS)+1 and never wraps; it saturates in DONE.
- Reset mid-frame returns to IDLE immediately with all outputs at their reset values. The next frame requires a fresh csFall, so cs already low at reset release starts nothing until it rises and falls again.

Test Plan:
- Reset, sampleValid with sampleData=0xA5, then cs low and 16 sclk pulses at clk/10 -> sampled bits 0000_1010_0101_0000, frameDone one pulse after the 16th fall, busy low after.
- Load 0x3C, cs low, 6 sclk pulses, then cs high -> frameAbort pulse, no frameDone, sdo=0, state IDLE. The next full frame returns 0x3C.
- Frame in progress with 0x81, sampleValid 0xFF at bit 7 -> current frame still yields 0x81, the following frame yields 0xFF.
- sampleValid 0x5A on the same clk as the synced csFall -> the frame carries 0x5A.
- 20 sclk pulses in one cs-low window with 0xC3 -> 0xC3 data, bits 17-20 read 0, a single frameDone.
- Assert rst_n=0 at bit 9, release it while cs is still low -> all outputs 0, no frame until cs cycles high then low.
